// File: rtl/elm_output_layer.sv
// ELM output layer: per-class MAC of hidden activations against beta ROM weights,
// followed by a sequential argmax scan that selects the winning class.
module elm_output_layer #(
  parameter int H_WIDTH    = 16,
  parameter int IDX_WIDTH  = 13,
  parameter int W_WIDTH    = 8,
  parameter int NUM_CLASS  = 10,
  parameter int CLS_WIDTH  = 4,
  parameter int ACC_WIDTH  = 40,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        h_valid,
  input  logic [H_WIDTH-1:0]          h_data,
  input  logic [IDX_WIDTH-1:0]        h_index,
  input  logic                        h_last,
  output logic [ADDR_WIDTH-1:0]       beta_addr,
  output logic                        beta_en,
  input  logic [W_WIDTH-1:0]          beta_data,
  output logic                        busy,
  output logic                        overrun,
  output logic                        result_valid,
  output logic [CLS_WIDTH-1:0]        class_id,
  output logic signed [ACC_WIDTH-1:0] class_score
);

  localparam int PW = H_WIDTH + W_WIDTH + 1;
  localparam logic [CLS_WIDTH-1:0] LAST_K = CLS_WIDTH'(NUM_CLASS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, MAC, ARGMAX, DONE} state_t;

  state_t                      state;
  logic [H_WIDTH-1:0]          h_lat;
  logic                        last_lat;
  logic [CLS_WIDTH-1:0]        k_addr;
  logic                        rd_vld;
  logic [CLS_WIDTH-1:0]        rd_k;
  logic [CLS_WIDTH-1:0]        scan_j;
  logic [CLS_WIDTH-1:0]        best_id;
  logic signed [ACC_WIDTH-1:0] best_score;
  logic signed [ACC_WIDTH-1:0] acc [NUM_CLASS];

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic                        take;

  // Activation is unsigned: a leading zero keeps it positive in the signed multiply.
  always_comb begin
    prod     = $signed(PW'({1'b0, h_lat})) * PW'($signed(beta_data));
    prod_ext = ACC_WIDTH'(prod);
    take     = (scan_j == '0) || (acc[scan_j] > best_score);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      h_lat        <= '0;
      last_lat     <= 1'b0;
      k_addr       <= '0;
      rd_vld       <= 1'b0;
      rd_k         <= '0;
      scan_j       <= '0;
      best_id      <= '0;
      best_score   <= '0;
      beta_addr    <= '0;
      beta_en      <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      result_valid <= 1'b0;
      class_id     <= '0;
      class_score  <= '0;
      for (int unsigned i = 0; i < NUM_CLASS; i++) acc[i] <= '0;
    end else if (start) begin
      for (int unsigned i = 0; i < NUM_CLASS; i++) acc[i] <= '0;
      overrun      <= 1'b0;
      result_valid <= 1'b0;
      beta_en      <= 1'b0;
      rd_vld       <= 1'b0;
      busy         <= 1'b0;
      state        <= WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (h_valid) begin
            h_lat     <= h_data;
            last_lat  <= h_last;
            k_addr    <= '0;
            beta_addr <= ADDR_WIDTH'(h_index) * ADDR_WIDTH'(NUM_CLASS);
            beta_en   <= 1'b1;
            rd_vld    <= 1'b0;
            busy      <= 1'b1;
            state     <= MAC;
          end
        end
        MAC: begin
          if (h_valid) overrun <= 1'b1;
          // Issue side runs one cycle ahead of the accumulate side (ROM latency).
          if (beta_en) begin
            if (k_addr != LAST_K) begin
              k_addr    <= k_addr + 1'b1;
              beta_addr <= beta_addr + 1'b1;
            end else begin
              beta_en <= 1'b0;
            end
          end
          rd_vld <= beta_en;
          rd_k   <= k_addr;
          if (rd_vld) begin
            acc[rd_k] <= acc[rd_k] + prod_ext;
            if (rd_k == LAST_K) begin
              if (last_lat) begin
                scan_j <= '0;
                state  <= ARGMAX;
              end else begin
                busy  <= 1'b0;
                state <= WAIT;
              end
            end
          end
        end
        ARGMAX: begin
          if (h_valid) overrun <= 1'b1;
          if (take) begin
            best_id    <= scan_j;
            best_score <= acc[scan_j];
          end
          if (scan_j == LAST_K) begin
            class_id     <= take ? scan_j : best_id;
            class_score  <= take ? acc[scan_j] : best_score;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            scan_j <= scan_j + 1'b1;
          end
        end
        default: ; // IDLE and DONE ignore h_valid
      endcase
    end
  end

endmodule

// File: doc/elm_output_layer.md
# elm_output_layer

Output-layer stage of the ELM inference pipeline, directly downstream of the hidden-layer datapath. It consumes each ReLU'd hidden-neuron value together with its neuron index and multiplies it by NUM_CLASS signed output weights (beta) fetched from an external synchronous ROM. It accumulates one score per class across all hidden neurons. After the last neuron it runs an argmax scan and presents the winning class and its score.

## Interface
Parameters:
- H_WIDTH, 16, hidden activation width (unsigned, post-ReLU)
- IDX_WIDTH, 13, hidden-neuron index width
- W_WIDTH, 8, beta weight width (two's complement)
- NUM_CLASS, 10, number of output classes
- CLS_WIDTH, 4, class-id width (≥ clog2(NUM_CLASS))
- ACC_WIDTH, 40, per-class accumulator width (signed)
- ADDR_WIDTH, 17, beta ROM address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  clears all accumulators and flags, arms collection
- h_valid  in  1  one-cycle pulse: h_data/h_index/h_last valid
- h_data  in  H_WIDTH  hidden activation, zero-extended for multiply
- h_index  in  IDX_WIDTH  neuron index of h_data
- h_last  in  1  marks the final neuron, qualified by h_valid
- beta_addr  out  ADDR_WIDTH  ROM address = h_index*NUM_CLASS + k
- beta_en  out  1  ROM read enable
- beta_data  in  W_WIDTH  ROM data, valid one cycle after beta_en
- busy  out  1  high in MAC and ARGMAX
- overrun  out  1  sticky: an h_valid was dropped
- result_valid  out  1  level, class_id/class_score valid
- class_id  out  CLS_WIDTH  winning class
- class_score  out  ACC_WIDTH  accumulator of winning class

## Operation
- States: IDLE, WAIT, MAC, ARGMAX, DONE.
- Reset: state IDLE; all accumulators 0; beta_addr 0, beta_en 0, busy 0, overrun 0, result_valid 0, class_id 0, class_score 0.
- start (any state, highest priority after rst): accumulators ← 0, overrun ← 0, result_valid ← 0, state → WAIT.
- IDLE/DONE: h_valid ignored.
- WAIT: on h_valid, latch h_data, h_index, h_last; k ← 0; → MAC.
- MAC: issue addresses k = 0..NUM_CLASS-1 on consecutive cycles. On each returned beta_data, acc[k] += $signed({1'b0,h_data}) * $signed(beta_data). The product is H_WIDTH+W_WIDTH+1 bits, sign-extended to ACC_WIDTH. No saturation; 2^IDX_WIDTH products cannot overflow 40 bits. After the last accumulate: → ARGMAX if the latched h_last = 1, else → WAIT.
- h_valid during MAC or ARGMAX: sample dropped, overrun ← 1 (sticky until start/rst).
- ARGMAX: sequential scan j = 0..NUM_CLASS-1, signed compare. Strictly-greater replaces, so a tie keeps the lowest index. Then → DONE.
- DONE: result_valid = 1. class_id and class_score are held until start or rst.
- rst mid-operation: immediate return to reset values. A partial MAC or scan is discarded.

## Timing
- h_valid sampled at edge E0. beta_en = 1 and beta_addr = idx*NUM_CLASS+k during cycle after E(k), k=0..NUM_CLASS-1.
- acc[k] updates at E(k+2). The last accumulate is at E(NUM_CLASS+1). The state leaves MAC at that edge. Per-neuron occupancy is NUM_CLASS+1 cycles (11 at default).
- busy rises at E0 and falls at E(NUM_CLASS+1) for non-last neurons.
- For a last neuron, ARGMAX occupies NUM_CLASS cycles. result_valid rises at E(2*NUM_CLASS+1) (E21 at default).
- beta_en is 0 outside MAC. The ROM has exactly one cycle of read latency. Back-to-back h_valid spacing must be ≥ NUM_CLASS+1 cycles; upstream spacing of ≥256 cycles satisfies this by construction.
- h_valid on the same edge as the MAC→WAIT transition counts as during MAC and is dropped.

## Test plan
- Reset: assert rst mid-MAC → all outputs at reset values on the same cycle. After release with no start, h_valid is ignored and beta_en stays 0.
- Single neuron: start; h_valid, h_data=100, h_index=3, h_last=1; ROM returns beta = k-5 for address 30+k → beta_addr runs 30..39. acc[k]=100*(k-5). result_valid at E21, class_id=9, class_score=400.
- Two neurons with negative weights: h_data=10 with all betas -1, then h_data=5 with beta[2]=+7, others -1 → class_id=2, class_score=25.
- Tie: all betas 4, one neuron h_data=1 → class_id=0, class_score=4.
- Overrun: second h_valid 5 cycles after the first → overrun=1 and the sample has no effect on scores. A subsequent start clears overrun.
- Extremes: 8192 neurons, each h_data=65535 and beta=-128 → class_score = -68718428160, matching the reference model exactly with no wrap.
